memory_responder: RTL

- Memory-side responder for the cache-to-memory request interface; it is the block that answers the cache controller's requests.
- Accepts one word request per cycle: address, write data and write enable.
- Writes are committed immediately.
- Reads return in order after a fixed pipelined LATENCY, with a valid strobe and the echoed address.
- Sits between the D-cache/I-cache controllers and the backing word store. It drives the MemoryStall input that the cache side already carries.

---
 rtl/memory_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/memory_responder.sv
// Purpose: memory-side responder; commits writes at once and returns reads in order with an echoed address.
// Latency: reads strobe MemoryDataValid LATENCY cycles after the request cycle; writes produce no response.
// Backpressure: MemoryStall holds off a write whose word is still waiting in the read pipeline; reads never stall.
module memory_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemoryRequest,
  input  logic        MemoryWriteEnable,
  input  logic [15:0] MemoryAddressIn,
  input  logic [15:0] MemoryDataIn,
  output logic        MemoryStall,
  output logic [15:0] MemoryDataOut,
  output logic        MemoryDataValid,
  output logic [15:0] MemoryAddressReturn
);

  // Backing word store; deliberately not reset.
  logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic [DEPTH_LOG2-1:0] reqIdx;
  logic                  readAccept;
  logic                  writeAccept;
  logic                  hazard;
  logic                  tailVld;
  logic [15:0]           tailAddr;

  assign reqIdx      = MemoryAddressIn[DEPTH_LOG2:1];
  assign MemoryStall = MemoryRequest & MemoryWriteEnable & hazard;
  // Requests seen while rst is high are dropped.
  assign readAccept  = MemoryRequest & ~MemoryWriteEnable & ~rst;
  assign writeAccept = MemoryRequest & MemoryWriteEnable & ~MemoryStall & ~rst;

  generate
    if (LATENCY == 1) begin : gNoStages
      // The array is sampled on the accept edge itself, so nothing is ever in flight.
      assign tailVld  = readAccept;
      assign tailAddr = MemoryAddressIn;
      assign hazard   = 1'b0;
    end else begin : gStages
      localparam int N = LATENCY - 1;
      logic [N-1:0] stgVld;
      logic [15:0]  stgAddr [N];

      // Fixed-length shift of read entries; no bubble squeezing keeps latency constant.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stgVld <= '0;
          for (int i = 0; i < N; i++) stgAddr[i] <= '0;
        end else begin
          stgVld[0]  <= readAccept;
          stgAddr[0] <= MemoryAddressIn;
          for (int i = 1; i < N; i++) begin
            stgVld[i]  <= stgVld[i-1];
            stgAddr[i] <= stgAddr[i-1];
          end
        end
      end

      // A write must wait while any unsampled read targets the same word.
      always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (stgVld[i] && (stgAddr[i][DEPTH_LOG2:1] == reqIdx)) hazard = 1'b1;
        end
      end

      assign tailVld  = stgVld[N-1];
      assign tailAddr = stgAddr[N-1];
    end
  endgenerate

  // Commit accepted writes to the store.
  always_ff @(posedge clk) begin
    if (writeAccept) mem[reqIdx] <= MemoryDataIn;
  end

  // Output register samples the store as the entry leaves the pipeline; zeros when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemoryDataValid     <= 1'b0;
      MemoryDataOut       <= '0;
      MemoryAddressReturn <= '0;
    end else begin
      MemoryDataValid     <= tailVld;
      MemoryDataOut       <= tailVld ? mem[tailAddr[DEPTH_LOG2:1]] : 16'h0000;
      MemoryAddressReturn <= tailVld ? tailAddr : 16'h0000;
    end
  end

endmodule
